// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: REPAIRMB sideband codes, lane-map encodings and partner FSM states.
package mbinit_pkg;

    localparam logic [3:0] MSG_START_REQ    = 4'b0001;
    localparam logic [3:0] MSG_START_RESP   = 4'b0010;
    localparam logic [3:0] MSG_END_REQ      = 4'b0011;
    localparam logic [3:0] MSG_END_RESP     = 4'b0100;
    localparam logic [3:0] MSG_DEGRADE_REQ  = 4'b0101;
    localparam logic [3:0] MSG_DEGRADE_RESP = 4'b0110;

    localparam logic [1:0] LANES_ALL  = 2'b11;
    localparam logic [1:0] LANES_LO   = 2'b01;
    localparam logic [1:0] LANES_HI   = 2'b10;
    localparam logic [1:0] LANES_NONE = 2'b00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_START_BUSY,
        ST_START_RESP,
        ST_HANDLE,
        ST_DEG_BUSY,
        ST_DEG_RESP,
        ST_EVAL,
        ST_REPEAT,
        ST_END_BUSY,
        ST_END_RESP,
        ST_DONE,
        ST_ERROR
    } repairmb_state_e;

    // States in which the partner is waiting on the link and residency is bounded.
    function automatic logic is_wait_state(input repairmb_state_e s);
        return s inside {ST_WAIT_START, ST_START_BUSY, ST_START_RESP, ST_HANDLE,
                         ST_DEG_BUSY, ST_DEG_RESP, ST_REPEAT, ST_END_BUSY, ST_END_RESP};
    endfunction

endpackage

// File: rtl/repairmb_timeout_cnt.sv
// Saturating residency counter; expire asserts on the last enabled cycle before LIMIT is reached.
module repairmb_timeout_cnt #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 8000
) (
    input  logic CLK,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // A LIMIT of zero turns the timeout off entirely.
    assign expire = (LIMIT != 0) && enable && (count >= LAST);

endmodule

// File: rtl/repairmb_partner_ctrl.sv
// Partner-side REPAIRMB responder: answers start/degrade/end requests and drives repeater reconfiguration.
module repairmb_partner_ctrl
    import mbinit_pkg::*;
#(
    parameter int MSG_W       = 4,
    parameter int MAX_REPEAT  = 2,
    parameter int TIMEOUT_CYC = 8000,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sb_busy,
    input  logic             i_sb_busy_fall,
    input  logic [MSG_W-1:0] i_rx_msg,
    input  logic             i_rx_valid,
    input  logic [1:0]       i_rx_lanes,
    input  logic             i_d2c_busy,
    input  logic             i_repeater_done,
    output logic             o_tx_valid,
    output logic [MSG_W-1:0] o_tx_msg,
    output logic             o_start_repeater,
    output logic [1:0]       o_lanes,
    output logic [2:0]       o_repeat_cnt,
    output logic             o_train_error,
    output logic             o_done
);

    localparam logic [MSG_W-1:0] START_REQ_C    = MSG_W'(MSG_START_REQ);
    localparam logic [MSG_W-1:0] START_RESP_C   = MSG_W'(MSG_START_RESP);
    localparam logic [MSG_W-1:0] END_REQ_C      = MSG_W'(MSG_END_REQ);
    localparam logic [MSG_W-1:0] END_RESP_C     = MSG_W'(MSG_END_RESP);
    localparam logic [MSG_W-1:0] DEG_REQ_C      = MSG_W'(MSG_DEGRADE_REQ);
    localparam logic [MSG_W-1:0] DEG_RESP_C     = MSG_W'(MSG_DEGRADE_RESP);
    localparam logic [2:0]       MAX_REPEAT_C   = 3'(MAX_REPEAT);

    repairmb_state_e  state, state_nxt;
    logic [1:0]       lane_map;
    logic             ok_flag;
    logic             tx_pulse;
    logic [MSG_W-1:0] tx_code;
    logic             rep_pulse;
    logic             tmo_expire;
    logic             accept_req;

    repairmb_timeout_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .CLK    (CLK),
        .rst    (rst),
        .clear  (state_nxt != state),
        .enable (is_wait_state(state)),
        .expire (tmo_expire)
    );

    assign accept_req = i_rx_valid && !i_d2c_busy;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enable loss outranks timeout, which outranks any message accepted in the same cycle.
    always_comb begin
        state_nxt = state;
        tx_pulse  = 1'b0;
        tx_code   = '0;
        rep_pulse = 1'b0;
        if (!i_en) begin
            state_nxt = ST_IDLE;
        end else if (tmo_expire) begin
            state_nxt = ST_ERROR;
        end else begin
            case (state)
                ST_IDLE:       state_nxt = ST_WAIT_START;
                ST_WAIT_START: if (i_rx_valid && i_rx_msg == START_REQ_C) state_nxt = ST_START_BUSY;
                ST_START_BUSY: if (!i_sb_busy) begin
                    state_nxt = ST_START_RESP;
                    tx_pulse  = 1'b1;
                    tx_code   = START_RESP_C;
                end
                ST_START_RESP: if (i_sb_busy_fall) state_nxt = ST_HANDLE;
                ST_HANDLE: if (accept_req) begin
                    if (i_rx_msg == DEG_REQ_C) begin
                        state_nxt = ST_DEG_BUSY;
                    end else if (i_rx_msg == END_REQ_C) begin
                        state_nxt = ok_flag ? ST_END_BUSY : ST_ERROR;
                    end
                end
                ST_DEG_BUSY: if (!i_sb_busy) begin
                    state_nxt = ST_DEG_RESP;
                    tx_pulse  = 1'b1;
                    tx_code   = DEG_RESP_C;
                end
                ST_DEG_RESP: if (i_sb_busy_fall) state_nxt = ST_EVAL;
                ST_EVAL: begin
                    case (lane_map)
                        LANES_ALL: state_nxt = ST_HANDLE;
                        LANES_LO, LANES_HI: begin
                            if (o_repeat_cnt < MAX_REPEAT_C) begin
                                state_nxt = ST_REPEAT;
                                rep_pulse = 1'b1;
                            end else begin
                                state_nxt = ST_ERROR;
                            end
                        end
                        default: state_nxt = ST_ERROR;
                    endcase
                end
                ST_REPEAT: if (i_repeater_done) state_nxt = ST_HANDLE;
                ST_END_BUSY: if (!i_sb_busy) begin
                    state_nxt = ST_END_RESP;
                    tx_pulse  = 1'b1;
                    tx_code   = END_RESP_C;
                end
                ST_END_RESP: if (i_sb_busy_fall) state_nxt = ST_DONE;
                ST_DONE:     state_nxt = ST_DONE;
                ST_ERROR:    state_nxt = ST_ERROR;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the transition decision; o_lanes survives an enable drop.
    always_ff @(posedge CLK) begin
        if (rst) begin
            o_tx_valid       <= 1'b0;
            o_tx_msg         <= '0;
            o_start_repeater <= 1'b0;
            o_lanes          <= LANES_ALL;
            o_repeat_cnt     <= '0;
            o_train_error    <= 1'b0;
            o_done           <= 1'b0;
            lane_map         <= LANES_NONE;
            ok_flag          <= 1'b0;
        end else begin
            o_tx_valid       <= tx_pulse;
            o_tx_msg         <= tx_code;
            o_start_repeater <= rep_pulse;
            o_train_error    <= (state_nxt == ST_ERROR);
            o_done           <= (state_nxt == ST_DONE);
            if (!i_en) begin
                o_repeat_cnt <= '0;
                ok_flag      <= 1'b0;
                lane_map     <= LANES_NONE;
            end else begin
                if (state == ST_HANDLE && state_nxt == ST_DEG_BUSY) begin
                    lane_map <= i_rx_lanes;
                end
                if (state == ST_EVAL && state_nxt == ST_HANDLE) begin
                    ok_flag <= 1'b1;
                end
                if (rep_pulse) begin
                    o_lanes      <= lane_map;
                    o_repeat_cnt <= o_repeat_cnt + 3'd1;
                    ok_flag      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_repairmb_partner_ctrl.sv
// Scoreboard bench for the REPAIRMB partner controller: directed exchanges, a sideband emulator and a response monitor.
module tb_repairmb_partner_ctrl;

    localparam logic [3:0] START_REQ  = 4'b0001;
    localparam logic [3:0] START_RESP = 4'b0010;
    localparam logic [3:0] END_REQ    = 4'b0011;
    localparam logic [3:0] END_RESP   = 4'b0100;
    localparam logic [3:0] DEG_REQ    = 4'b0101;
    localparam logic [3:0] DEG_RESP   = 4'b0110;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       i_en = 1'b0;
    logic       emu_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic       i_sb_busy;
    logic       i_sb_busy_fall = 1'b0;
    logic [3:0] i_rx_msg = '0;
    logic       i_rx_valid = 1'b0;
    logic [1:0] i_rx_lanes = '0;
    logic       i_d2c_busy = 1'b0;
    logic       i_repeater_done = 1'b0;

    logic       o_tx_valid, o_start_repeater, o_train_error, o_done;
    logic [3:0] o_tx_msg;
    logic [1:0] o_lanes;
    logic [2:0] o_repeat_cnt;

    logic       z_tx_valid, z_start_repeater, z_train_error, z_done;
    logic [3:0] z_tx_msg;
    logic [1:0] z_lanes;
    logic [2:0] z_repeat_cnt;

    int         checks = 0;
    int         passes = 0;
    int         tx_count = 0;
    int         rep_pulses = 0;
    bit         z_err_seen = 1'b0;
    logic [3:0] exp_q[$];

    assign i_sb_busy = emu_busy | hold_busy;

    always #5 CLK = ~CLK;

    repairmb_partner_ctrl #(.MSG_W(4), .MAX_REPEAT(2), .TIMEOUT_CYC(20), .CNT_W(16)) dut (
        .CLK(CLK), .rst(rst), .i_en(i_en), .i_sb_busy(i_sb_busy), .i_sb_busy_fall(i_sb_busy_fall),
        .i_rx_msg(i_rx_msg), .i_rx_valid(i_rx_valid), .i_rx_lanes(i_rx_lanes), .i_d2c_busy(i_d2c_busy),
        .i_repeater_done(i_repeater_done), .o_tx_valid(o_tx_valid), .o_tx_msg(o_tx_msg),
        .o_start_repeater(o_start_repeater), .o_lanes(o_lanes), .o_repeat_cnt(o_repeat_cnt),
        .o_train_error(o_train_error), .o_done(o_done)
    );

    repairmb_partner_ctrl #(.MSG_W(4), .MAX_REPEAT(2), .TIMEOUT_CYC(0), .CNT_W(16)) dut_notmo (
        .CLK(CLK), .rst(rst), .i_en(i_en), .i_sb_busy(i_sb_busy), .i_sb_busy_fall(i_sb_busy_fall),
        .i_rx_msg(i_rx_msg), .i_rx_valid(i_rx_valid), .i_rx_lanes(i_rx_lanes), .i_d2c_busy(i_d2c_busy),
        .i_repeater_done(i_repeater_done), .o_tx_valid(z_tx_valid), .o_tx_msg(z_tx_msg),
        .o_start_repeater(z_start_repeater), .o_lanes(z_lanes), .o_repeat_cnt(z_repeat_cnt),
        .o_train_error(z_train_error), .o_done(z_done)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code, input logic [1:0] lanes,
                                 input bit expect_resp, input logic [3:0] resp);
        if (expect_resp) exp_q.push_back(resp);
        i_rx_msg   = code;
        i_rx_lanes = lanes;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic waitResponses(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        checkOutput(name, exp_q.size(), 0);
        repeat (6) tick();
    endtask

    task automatic resetDut();
        rst        = 1'b1;
        i_en       = 1'b0;
        hold_busy  = 1'b0;
        i_d2c_busy = 1'b0;
        repeat (2) tick();
        rst        = 1'b0;
        tick();
        tx_count   = 0;
        rep_pulses = 0;
        exp_q.delete();
    endtask

    task automatic startExchange(input string name);
        i_en = 1'b1;
        tick();
        applyStimulus(START_REQ, 2'b11, 1'b1, START_RESP);
        waitResponses(name);
    endtask

    task automatic pulseRepeaterDone();
        i_repeater_done = 1'b1;
        tick();
        i_repeater_done = 1'b0;
        tick();
    endtask

    // Sideband emulator: each send keeps TX busy for two cycles, then reports the falling edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (o_tx_valid) begin
                emu_busy = 1'b1;
                tick();
                tick();
                emu_busy = 1'b0;
                i_sb_busy_fall = 1'b1;
                tick();
                i_sb_busy_fall = 1'b0;
            end
        end
    end

    // Monitor: every response the DUT sends must match the oldest expected one.
    always @(negedge CLK) begin
        if (o_tx_valid) begin
            tx_count++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_tx: got msg %0d, expected no response", o_tx_msg);
            end else begin
                checkOutput("tx_msg", int'(o_tx_msg), int'(exp_q.pop_front()));
            end
        end
        if (o_start_repeater) rep_pulses++;
        if (z_train_error) z_err_seen = 1'b1;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) tick();
        checkOutput("rst_tx_valid", o_tx_valid, 0);
        checkOutput("rst_tx_msg", o_tx_msg, 0);
        checkOutput("rst_lanes", o_lanes, 3);
        checkOutput("rst_repeat_cnt", o_repeat_cnt, 0);
        checkOutput("rst_train_error", o_train_error, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_start_repeater", o_start_repeater, 0);

        $display("[TB] clean path");
        resetDut();
        startExchange("clean_start");
        applyStimulus(DEG_REQ, 2'b11, 1'b1, DEG_RESP);
        waitResponses("clean_degrade");
        checkOutput("clean_no_done_yet", o_done, 0);
        applyStimulus(END_REQ, 2'b11, 1'b1, END_RESP);
        waitResponses("clean_end");
        checkOutput("clean_done", o_done, 1);
        checkOutput("clean_repeat_cnt", o_repeat_cnt, 0);
        checkOutput("clean_lanes", o_lanes, 3);
        checkOutput("clean_error", o_train_error, 0);
        checkOutput("clean_tx_count", tx_count, 3);

        $display("[TB] single repeat");
        resetDut();
        startExchange("rep1_start");
        applyStimulus(DEG_REQ, 2'b01, 1'b1, DEG_RESP);
        waitResponses("rep1_degrade_lo");
        checkOutput("rep1_lanes", o_lanes, 1);
        checkOutput("rep1_repeat_cnt", o_repeat_cnt, 1);
        checkOutput("rep1_pulses", rep_pulses, 1);
        pulseRepeaterDone();
        applyStimulus(DEG_REQ, 2'b11, 1'b1, DEG_RESP);
        waitResponses("rep1_degrade_all");
        applyStimulus(END_REQ, 2'b11, 1'b1, END_RESP);
        waitResponses("rep1_end");
        checkOutput("rep1_done", o_done, 1);
        checkOutput("rep1_final_cnt", o_repeat_cnt, 1);

        $display("[TB] repeat exhaustion");
        resetDut();
        startExchange("exh_start");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(DEG_REQ, 2'b10, 1'b1, DEG_RESP);
            waitResponses("exh_degrade");
            if (k < 2) pulseRepeaterDone();
        end
        checkOutput("exh_error", o_train_error, 1);
        checkOutput("exh_repeat_cnt", o_repeat_cnt, 2);
        checkOutput("exh_lanes", o_lanes, 2);
        checkOutput("exh_pulses", rep_pulses, 2);
        applyStimulus(END_REQ, 2'b11, 1'b0, 4'b0000);
        repeat (8) tick();
        checkOutput("exh_no_end_resp", tx_count, 4);
        checkOutput("exh_done", o_done, 0);

        $display("[TB] lanes none");
        resetDut();
        startExchange("none_start");
        applyStimulus(DEG_REQ, 2'b00, 1'b1, DEG_RESP);
        waitResponses("none_degrade");
        checkOutput("none_error", o_train_error, 1);
        checkOutput("none_pulses", rep_pulses, 0);

        $display("[TB] early end request");
        resetDut();
        startExchange("early_start");
        applyStimulus(END_REQ, 2'b11, 1'b0, 4'b0000);
        repeat (4) tick();
        checkOutput("early_error", o_train_error, 1);
        checkOutput("early_tx_count", tx_count, 1);

        $display("[TB] abort in degrade busy");
        resetDut();
        startExchange("abort_start");
        applyStimulus(DEG_REQ, 2'b01, 1'b1, DEG_RESP);
        waitResponses("abort_degrade_lo");
        pulseRepeaterDone();
        hold_busy = 1'b1;
        applyStimulus(DEG_REQ, 2'b11, 1'b0, 4'b0000);
        tick();
        i_en = 1'b0;
        tick();
        hold_busy = 1'b0;
        checkOutput("abort_tx_valid", o_tx_valid, 0);
        checkOutput("abort_tx_msg", o_tx_msg, 0);
        checkOutput("abort_start_rep", o_start_repeater, 0);
        checkOutput("abort_repeat_cnt", o_repeat_cnt, 0);
        checkOutput("abort_error", o_train_error, 0);
        checkOutput("abort_done", o_done, 0);
        checkOutput("abort_lanes_kept", o_lanes, 1);
        repeat (5) tick();
        checkOutput("abort_tx_count", tx_count, 2);

        $display("[TB] d2c busy blocks degrade");
        resetDut();
        startExchange("d2c_start");
        i_d2c_busy = 1'b1;
        applyStimulus(DEG_REQ, 2'b11, 1'b0, 4'b0000);
        repeat (8) tick();
        i_d2c_busy = 1'b0;
        checkOutput("d2c_no_tx", tx_count, 1);
        checkOutput("d2c_no_error", o_train_error, 0);
        applyStimulus(DEG_REQ, 2'b11, 1'b1, DEG_RESP);
        waitResponses("d2c_degrade_after");

        $display("[TB] residency timeout");
        resetDut();
        z_err_seen = 1'b0;
        i_en = 1'b1;
        tick();
        repeat (19) tick();
        checkOutput("tmo_before", o_train_error, 0);
        tick();
        checkOutput("tmo_at_limit", o_train_error, 1);
        repeat (1000) tick();
        checkOutput("tmo_disabled_error", int'(z_err_seen), 0);
        checkOutput("tmo_disabled_now", z_train_error, 0);
        checkOutput("tmo_tx_count", tx_count, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
